// File: rtl/ori_ram_seq.sv
// Orion RAM time-slot sequencer: video channel 0 plus round-robin requestors 1..N_CH-1.
// Optional ORI_SEQ_TURBO_EN hands video slots to the requestors during vertical blank.
module ori_ram_seq #(
    parameter int CYC_LEN   = 4,
    parameter int N_CH      = 3,
    parameter int VID_EVERY = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            cke_i,
    input  logic            vblank_i,
    input  logic [N_CH-1:0] req_i,
    input  logic [N_CH-1:0] wr_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [N_CH-1:0] ack_o,
    output logic            acc_cpu_o,
    output logic            cke_ras_n_o,
    output logic            pix_ld_o,
    output logic            ram_ce_o,
    output logic            ram_oe_o,
    output logic            ram_we_o
);
    localparam int PW = $clog2(CYC_LEN);
    localparam int CW = (VID_EVERY > 1) ? $clog2(VID_EVERY) : 1;
    localparam int OW = $clog2(N_CH);
    localparam int SW = OW + 1;
    localparam logic [PW-1:0] PH_LAST  = PW'(CYC_LEN - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(VID_EVERY - 1);

    logic [1:0]      r_rst_sync;
    logic            w_rst_n;
    logic            r_started;
    logic [PW-1:0]   r_phase;
    logic [CW-1:0]   r_cyc;
    logic [OW-1:0]   r_rr_ptr;
    logic [OW-1:0]   r_owner;
    logic            r_own_vld;
    logic            r_wr;
    logic [N_CH-1:0] r_gnt;
    logic            r_ce, r_oe, r_we, r_ras_n;

    logic            w_wrap, w_bound, w_vid;
    logic [PW-1:0]   w_phase_nx;
    logic [CW-1:0]   w_cyc_nx;
    logic            w_rr_hit;
    logic [OW-1:0]   w_rr_sel;
    logic [SW-1:0]   w_sum;
    logic [OW-1:0]   w_idx;
    logic            w_vld_nx, w_wr_nx;
    logic [OW-1:0]   w_owner_nx;
    logic            w_unused;

    // Reset asserts asynchronously, releases on a clock edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_wrap     = !r_started || (r_phase == PH_LAST);
    assign w_bound    = cke_i && w_wrap;
    assign w_phase_nx = w_wrap ? '0 : r_phase + 1'b1;
    assign w_cyc_nx   = (!r_started || r_cyc == CYC_LAST) ? '0 : r_cyc + 1'b1;

`ifdef ORI_SEQ_TURBO_EN
    assign w_vid    = (w_cyc_nx == '0) && !vblank_i;
    assign w_unused = ^{req_i[0], wr_i[0]};
`else
    assign w_vid    = (w_cyc_nx == '0);
    assign w_unused = ^{vblank_i, req_i[0], wr_i[0]};
`endif

    // Descending scan so the channel nearest after rr_ptr is written last and wins.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_sel = r_rr_ptr;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = N_CH - 1; k >= 1; k--) begin
            w_sum = {1'b0, r_rr_ptr} + SW'(k);
            if (w_sum > SW'(N_CH - 1)) w_sum = w_sum - SW'(N_CH - 1);
            w_idx = w_sum[OW-1:0];
            if (req_i[w_idx]) begin
                w_rr_hit = 1'b1;
                w_rr_sel = w_idx;
            end
        end
    end

    always_comb begin
        w_vld_nx   = r_own_vld;
        w_owner_nx = r_owner;
        w_wr_nx    = r_wr;
        if (w_bound) begin
            w_vld_nx   = w_vid || w_rr_hit;
            w_owner_nx = w_vid ? '0 : w_rr_sel;
            w_wr_nx    = !w_vid && w_rr_hit && wr_i[w_rr_sel];
        end
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_started <= 1'b0;
            r_phase   <= '0;
            r_cyc     <= '0;
            r_rr_ptr  <= OW'(N_CH - 1);
            r_owner   <= '0;
            r_own_vld <= 1'b0;
            r_wr      <= 1'b0;
            r_gnt     <= '0;
            r_ce      <= 1'b0;
            r_oe      <= 1'b0;
            r_we      <= 1'b0;
            r_ras_n   <= 1'b1;
        end else if (cke_i) begin
            r_started <= 1'b1;
            r_phase   <= w_phase_nx;
            r_own_vld <= w_vld_nx;
            r_owner   <= w_owner_nx;
            r_wr      <= w_wr_nx;
            if (w_bound) begin
                r_cyc <= w_cyc_nx;
                r_gnt <= w_vld_nx ? (N_CH'(1) << w_owner_nx) : '0;
                if (!w_vid && w_rr_hit) r_rr_ptr <= w_rr_sel;
            end
            // Strobes are registered from next-state so they switch cleanly with the phase.
            r_ce    <= w_vld_nx;
            r_ras_n <= !(w_vld_nx && w_phase_nx == '0);
            r_oe    <= w_vld_nx && !w_wr_nx && (w_phase_nx != '0);
            r_we    <= w_vld_nx && w_wr_nx && (w_phase_nx != '0) && (w_phase_nx != PH_LAST);
        end
    end

    always_comb begin
        ack_o = '0;
        if (cke_i && r_own_vld && r_phase == PH_LAST) ack_o[r_owner] = 1'b1;
    end

    assign gnt_o       = r_gnt;
    assign pix_ld_o    = ack_o[0];
    assign acc_cpu_o   = r_own_vld && (r_owner != '0);
    assign cke_ras_n_o = r_ras_n;
    assign ram_ce_o    = r_ce;
    assign ram_oe_o    = r_oe;
    assign ram_we_o    = r_we;
endmodule

// File: tb/tb_ori_ram_seq.sv
// Directed bench for ori_ram_seq at defaults (CYC_LEN=4, N_CH=3, VID_EVERY=2), cke every 4th clk.
module tb_ori_ram_seq;
    logic       clk = 1'b0, rst_n = 1'b0, cke = 1'b0, vblank = 1'b0;
    logic [2:0] req = 3'b000, wr = 3'b000;
    logic [2:0] gnt_o, ack_o;
    logic       acc_cpu_o, cke_ras_n_o, pix_ld_o, ram_ce_o, ram_oe_o, ram_we_o;

    int n_chk = 0, n_pass = 0;

    logic [3:0][2:0] c_g;
    logic [3:0]      c_oe, c_we, c_ce, c_ras, c_acc;
    logic [2:0]      c_ack;
    logic            c_pix, c_stray;

    ori_ram_seq dut (
        .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .vblank_i(vblank),
        .req_i(req), .wr_i(wr), .gnt_o(gnt_o), .ack_o(ack_o),
        .acc_cpu_o(acc_cpu_o), .cke_ras_n_o(cke_ras_n_o), .pix_ld_o(pix_ld_o),
        .ram_ce_o(ram_ce_o), .ram_oe_o(ram_oe_o), .ram_we_o(ram_we_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One cke tick: three idle clocks, then one enabled clock; state recorded after the tick.
    task automatic tick(input int p);
        repeat (3) begin
            @(posedge clk); #1;
            if (ack_o != 3'b000) c_stray = 1'b1;
        end
        cke = 1'b1; #1;
        if (p == 0) begin
            c_ack = ack_o;
            c_pix = pix_ld_o;
        end else if (ack_o != 3'b000) c_stray = 1'b1;
        @(posedge clk); #1;
        cke = 1'b0;
        c_g[p] = gnt_o;  c_oe[p] = ram_oe_o;  c_we[p] = ram_we_o;
        c_ce[p] = ram_ce_o; c_ras[p] = cke_ras_n_o; c_acc[p] = acc_cpu_o;
    endtask

    task automatic cyc();
        c_stray = 1'b0;
        for (int p = 0; p < 4; p++) tick(p);
    endtask

    // eoe/ewe bit i = strobe level in phase i; eack = ack seen on this cycle's boundary tick.
    task automatic cyc_chk(input string tag, input logic [2:0] eg, input logic [3:0] eoe,
                           input logic [3:0] ewe, input logic eacc, input logic [2:0] eack);
        chk({tag, ".gnt"},   c_g,   {4{eg}});
        chk({tag, ".ce"},    c_ce,  (eg != 3'b000) ? 4'b1111 : 4'b0000);
        chk({tag, ".ras_n"}, c_ras, (eg != 3'b000) ? 4'b1110 : 4'b1111);
        chk({tag, ".oe"},    c_oe,  eoe);
        chk({tag, ".we"},    c_we,  ewe);
        chk({tag, ".acc"},   c_acc, {4{eacc}});
        chk({tag, ".ack"},   c_ack, eack);
        chk({tag, ".pix"},   c_pix, eack[0]);
        chk({tag, ".stray"}, c_stray, 1'b0);
    endtask

    initial begin
        #23;
        chk("rst.gnt", gnt_o, 3'b000);
        chk("rst.ack", ack_o, 3'b000);
        chk("rst.ce_oe_we", {ram_ce_o, ram_oe_o, ram_we_o}, 3'b000);
        chk("rst.ras_n", cke_ras_n_o, 1'b1);
        chk("rst.acc_pix", {acc_cpu_o, pix_ld_o}, 2'b00);
        @(posedge clk); #1 rst_n = 1'b1;

        // Idle alternation: video, idle, video.
        cyc(); cyc_chk("A", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b000);
        cyc(); cyc_chk("B", 3'b000, 4'b0000, 4'b0000, 1'b0, 3'b001);
        cyc(); cyc_chk("C", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b000);

        // Single CPU read on ch1.
        req = 3'b010;
        cyc(); cyc_chk("D", 3'b010, 4'b1110, 4'b0000, 1'b1, 3'b001);
        cyc(); cyc_chk("E", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b010);
        req = 3'b000;
        cyc(); cyc_chk("F", 3'b000, 4'b0000, 4'b0000, 1'b0, 3'b001);

        // ch1 (write) and ch2 (read) both held; rr_ptr is 1 so ch2 goes first.
        req = 3'b110; wr = 3'b010;
        cyc(); cyc_chk("G", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b000);
        cyc(); cyc_chk("H", 3'b100, 4'b1110, 4'b0000, 1'b1, 3'b001);
        cyc(); cyc_chk("I", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b100);
        cyc(); cyc_chk("J", 3'b010, 4'b0000, 4'b0110, 1'b1, 3'b001);
        cyc(); cyc_chk("K", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b010);
        cyc(); cyc_chk("L", 3'b100, 4'b1110, 4'b0000, 1'b1, 3'b001);
        cyc(); cyc_chk("M", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b100);
        cyc(); cyc_chk("N", 3'b010, 4'b0000, 4'b0110, 1'b1, 3'b001);
        cyc(); cyc_chk("O", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b010);

        // ch1 read interrupted by reset in phase 2.
        req = 3'b010; wr = 3'b000;
        c_stray = 1'b0;
        tick(0); tick(1); tick(2);
        chk("P.ack", c_ack, 3'b001);
        chk("P.ph2", {gnt_o, ram_ce_o, ram_oe_o, acc_cpu_o}, {3'b010, 3'b111});
        @(posedge clk); #2 rst_n = 1'b0; #1;
        chk("P.rst_gnt", gnt_o, 3'b000);
        chk("P.rst_strb", {ram_ce_o, ram_oe_o, ram_we_o, acc_cpu_o}, 4'b0000);
        chk("P.rst_ras", cke_ras_n_o, 1'b1);
        chk("P.rst_ack", ack_o, 3'b000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        vblank = 1'b1;

        // Restart from a video slot; ch1 re-granted and acked, vblank has no effect.
        cyc(); cyc_chk("Q", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b000);
        cyc(); cyc_chk("R", 3'b010, 4'b1110, 4'b0000, 1'b1, 3'b001);
        req = 3'b000;
        cyc(); cyc_chk("S", 3'b001, 4'b1110, 4'b0000, 1'b0, 3'b010);
        vblank = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ori_ram_seq.md
Name: ori_ram_seq

Overview:
- Parametrised RAM time-slot sequencer for the Orion core.
- Generalises the fixed video/CPU alternation to N requestor channels with a configurable memory-cycle length and video-slot ratio.
- Sits between the 10 MHz clock-enable generator, the video pixel fetch, the CPU and extra requestors (DMA, disk), and drives the RAM strobes and address-mux select.
- Channel 0 is always video. Channels 1..N_CH-1 share the remaining cycles round-robin.

Parameters:
- CYC_LEN, 4: cke_i ticks per memory cycle. Legal range 3..16.
- N_CH, 3: channel count including video channel 0. Legal range 2..8.
- VID_EVERY, 2: one of every VID_EVERY memory cycles is the video cycle. Legal range 1..8; 1 means all cycles are video.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  sequencer tick enable (10 MHz).
- vblank_i  in  1  vertical blank from the timing generator.
- req_i  in  N_CH  level request per channel; bit 0 ignored.
- wr_i  in  N_CH  1 = write, per channel; sampled at grant; bit 0 ignored.
- gnt_o  out  N_CH  one-hot owner of the current cycle; 0 = idle.
- ack_o  out  N_CH  one-clk completion pulse to the owner.
- acc_cpu_o  out  1  current owner is a non-video channel (address-mux select).
- cke_ras_n_o  out  1  address-latch strobe, low during phase 0 of an owned cycle.
- pix_ld_o  out  1  video data-load pulse; equal to ack_o[0].
- ram_ce_o  out  1  RAM chip enable.
- ram_oe_o  out  1  RAM output enable.
- ram_we_o  out  1  RAM write enable.

Behaviour:
- Reset (async assert, sync release on clk_i):
  - phase=0, cyc=0, rr_ptr=N_CH-1, owner=none, gnt_o=0.
  - ack_o=0, pix_ld_o=0, acc_cpu_o=0, cke_ras_n_o=1, ram_ce_o=ram_oe_o=ram_we_o=0.
  - First owned cycle begins at the first slot boundary after release.
- State advances only on clk_i edges with cke_i=1.
- Phase counter runs 0..CYC_LEN-1 and wraps. Cycle counter runs 0..VID_EVERY-1 and increments on each phase wrap.
- Slot boundary (cke_i=1, phase=CYC_LEN-1, or the first cke_i tick after reset):
  - New owner, gnt_o and latched write flag are registered and become valid together with phase=0.
  - If next cyc==0, owner = channel 0, read.
  - Otherwise, round-robin over channels 1..N_CH-1, searching from rr_ptr+1 and wrapping. The first channel with req_i set wins and rr_ptr updates to it.
  - No request gives an idle cycle: gnt_o=0 and all strobes inactive.
- Strobes (registered, owned cycles only):
  - ram_ce_o=1 for phases 0..CYC_LEN-1.
  - cke_ras_n_o=0 in phase 0.
  - Read: ram_oe_o=1 for phases 1..CYC_LEN-1.
  - Write: ram_we_o=1 for phases 1..CYC_LEN-2; ram_oe_o stays 0.
  - ram_oe_o and ram_we_o are never both 1.
- ack_o[owner]:
  - High for exactly the one clk_i cycle where phase=CYC_LEN-1 and cke_i=1.
  - The requestor samples RAM data on that edge.
  - Decoded from registered state AND cke_i; the only output with a cke_i combinational path.
- acc_cpu_o = owner is in 1..N_CH-1, held for the whole cycle.
- Request handshake:
  - A requestor holds req_i until its ack.
  - A request dropped mid-cycle does not abort the current cycle.
  - A request raised mid-cycle waits for the next boundary.
  - Simultaneous requests: strict rotation. A channel waits at most (N_CH-1) non-video cycles.
- VID_EVERY=1: non-video channels are never granted (unless ORI_SEQ_TURBO_EN).
- Reset asserted mid-cycle: all strobes drop immediately (async), no ack is issued, and the interrupted request is re-arbitrated after release.

Optional Feature:
- Macro: ORI_SEQ_TURBO_EN.
- Defined: when vblank_i=1 at a slot boundary whose cycle is a video cycle, that cycle is arbitrated among channels 1..N_CH-1 as a normal cycle. No pix_ld_o is issued; if nothing is requested, the cycle is idle.
- Undefined: vblank_i is ignored and every video cycle is owned by channel 0 with a read and pix_ld_o.

Test Plan (defaults CYC_LEN=4, N_CH=3, VID_EVERY=2; cke_i every 4th clk_i):
- Reset, req_i=0 → gnt_o alternates 3'b001 and 3'b000 per 4-tick cycle. pix_ld_o pulses every 8 ticks. ram_ce_o high only in video cycles. ram_we_o never 1.
- req_i=3'b010, wr_i=0 → gnt_o=3'b010 in the cycle after a video cycle. ram_oe_o on phases 1..3. ack_o=3'b010 one clk at phase 3. acc_cpu_o=1 for that cycle.
- req_i=3'b110 held continuously → non-video grants go ch1, ch2, ch1, ch2. Each ack is a single clk pulse. Video cycles are interleaved unchanged.
- wr_i[1]=1 → ram_we_o high phases 1..2, ram_oe_o=0, cke_ras_n_o low phase 0 only.
- Assert rst_n_i=0 at phase 2 of a CPU cycle → ram_ce_o and gnt_o drop the same cycle, no ack. After release the channel is re-granted and acked.
- ORI_SEQ_TURBO_EN, vblank_i=1, req_i=3'b010 → ch1 granted every cycle and pix_ld_o stays 0. With vblank_i=0 the video slots return.
